// File: rtl/nibble_stream_rx.sv
// Receiver for the framed LSB-first nibble test-pattern stream: deserializes words and counts them.
// Sequence checking (rx_err, err_count, locked) is built only when NIBBLE_RX_SEQ_CHECK_EN is defined.
module nibble_stream_rx #(
  parameter int NIBBLE_W   = 4,
  parameter int GAP_CYCLES = 1,
  parameter int START_DLY  = 1,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                SSEL,
  input  logic                MOSI,
  output logic [NIBBLE_W-1:0] rx_data,
  output logic                rx_valid,
  output logic                rx_err,
  output logic                locked,
  output logic [CNT_W-1:0]    word_count,
  output logic [CNT_W-1:0]    err_count
);

  localparam int IDX_W = $clog2(NIBBLE_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEAD = 2'd1,
    ST_BITS = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t              state_q;
  logic                ssel_s1_q, ssel_s2_q, ssel_prev_q;
  logic                mosi_s1_q, mosi_s2_q;
  logic [IDX_W-1:0]    bit_idx_q;
  logic [3:0]          dly_q;
  logic [3:0]          gap_q;
  logic [NIBBLE_W-1:0] shift_q;
  logic [NIBBLE_W-1:0] shift_d;
  logic [NIBBLE_W-1:0] rx_data_q;
  logic                rx_valid_q;
  logic [CNT_W-1:0]    word_count_q;
  logic [CNT_W-1:0]    word_count_d;
  logic                fall_s;
  logic                last_bit_s;

  // Two-flop synchronizers plus previous-SSEL flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ssel_s1_q   <= 1'b1;
      ssel_s2_q   <= 1'b1;
      ssel_prev_q <= 1'b1;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
    end else begin
      ssel_s1_q   <= SSEL;
      ssel_s2_q   <= ssel_s1_q;
      ssel_prev_q <= ssel_s2_q;
      mosi_s1_q   <= MOSI;
      mosi_s2_q   <= mosi_s1_q;
    end
  end

  assign fall_s     = ssel_prev_q & ~ssel_s2_q;
  assign last_bit_s = (bit_idx_q == IDX_W'(NIBBLE_W - 1));
  assign shift_d    = {mosi_s2_q, shift_q[NIBBLE_W-1:1]};

  // Saturating word counter next value.
  always_comb begin
    word_count_d = word_count_q;
    if (word_count_q == {CNT_W{1'b1}}) begin
      word_count_d = word_count_q;
    end else begin
      word_count_d = word_count_q + CNT_W'(1);
    end
  end

`ifdef NIBBLE_RX_SEQ_CHECK_EN
  logic [NIBBLE_W-1:0] expected_q;
  logic                first_q;
  logic                locked_q;
  logic                rx_err_q;
  logic [CNT_W-1:0]    err_count_q;
  logic [CNT_W-1:0]    err_count_d;
  logic                mismatch_s;

  assign mismatch_s = (shift_d != expected_q);

  // Saturating error counter next value.
  always_comb begin
    err_count_d = err_count_q;
    if (err_count_q == {CNT_W{1'b1}}) begin
      err_count_d = err_count_q;
    end else begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end
`endif

  // Frame FSM; a restart on a falling edge outranks frame end and word completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_idx_q    <= '0;
      dly_q        <= 4'd0;
      gap_q        <= 4'd0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      word_count_q <= '0;
`ifdef NIBBLE_RX_SEQ_CHECK_EN
      expected_q   <= {NIBBLE_W{1'b1}};
      first_q      <= 1'b0;
      locked_q     <= 1'b0;
      rx_err_q     <= 1'b0;
      err_count_q  <= '0;
`endif
    end else begin
      rx_valid_q <= 1'b0;
`ifdef NIBBLE_RX_SEQ_CHECK_EN
      rx_err_q   <= 1'b0;
`endif
      if (fall_s) begin
        state_q   <= (START_DLY == 0) ? ST_BITS : ST_LEAD;
        bit_idx_q <= '0;
        dly_q     <= 4'(START_DLY);
`ifdef NIBBLE_RX_SEQ_CHECK_EN
        locked_q   <= 1'b0;
        expected_q <= {NIBBLE_W{1'b1}};
        first_q    <= 1'b1;
`endif
      end else if (ssel_s2_q) begin
        state_q   <= ST_IDLE;
        bit_idx_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_IDLE;
          ST_LEAD: begin
            dly_q <= dly_q - 4'd1;
            if (dly_q <= 4'd1) begin
              state_q <= ST_BITS;
            end else begin
              state_q <= ST_LEAD;
            end
          end
          ST_BITS: begin
            shift_q <= shift_d;
            if (last_bit_s) begin
              state_q      <= ST_GAP;
              gap_q        <= 4'(GAP_CYCLES);
              bit_idx_q    <= '0;
              rx_data_q    <= shift_d;
              rx_valid_q   <= 1'b1;
              word_count_q <= word_count_d;
`ifdef NIBBLE_RX_SEQ_CHECK_EN
              rx_err_q <= mismatch_s;
              first_q  <= 1'b0;
              if (mismatch_s) begin
                err_count_q <= err_count_d;
              end else begin
                err_count_q <= err_count_q;
              end
              // Preamble hit restarts the count at 1; otherwise follow the received word.
              if (first_q && !mismatch_s) begin
                locked_q   <= 1'b1;
                expected_q <= NIBBLE_W'(1);
              end else begin
                expected_q <= shift_d + NIBBLE_W'(1);
              end
`endif
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end
          ST_GAP: begin
            if (gap_q <= 4'd1) begin
              state_q   <= ST_BITS;
              bit_idx_q <= '0;
            end else begin
              gap_q <= gap_q - 4'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign word_count = word_count_q;
`ifdef NIBBLE_RX_SEQ_CHECK_EN
  assign rx_err    = rx_err_q;
  assign locked    = locked_q;
  assign err_count = err_count_q;
`else
  assign rx_err    = 1'b0;
  assign locked    = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_nibble_stream_rx.sv
// Scoreboard bench for nibble_stream_rx: a reference model queues each completed word's expected outputs.
module tb_nibble_stream_rx;
  localparam int W    = 4;
  localparam int GAP  = 1;
  localparam int SDLY = 1;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          SSEL;
  logic          MOSI;
  logic [W-1:0]  rx_data;
  logic          rx_valid;
  logic          rx_err;
  logic          locked;
  logic [CW-1:0] word_count;
  logic [CW-1:0] err_count;

  always #5 clk = ~clk;

  nibble_stream_rx #(.NIBBLE_W(W), .GAP_CYCLES(GAP), .START_DLY(SDLY), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .SSEL(SSEL), .MOSI(MOSI),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .locked(locked),
    .word_count(word_count), .err_count(err_count)
  );

  typedef struct packed {
    logic [W-1:0]  data;
    logic          err;
    logic          lock;
    logic [CW-1:0] wc;
    logic [CW-1:0] ec;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;

  logic [W-1:0]  m_exp;
  logic          m_first;
  logic          m_lock;
  logic [CW-1:0] m_wc;
  logic [CW-1:0] m_ec;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic m);
    @(negedge clk);
    SSEL = s;
    MOSI = m;
  endtask

  task automatic model_word(input logic [W-1:0] w);
    exp_t e;
    logic mism;
    if (m_wc != {CW{1'b1}}) m_wc = m_wc + 1'b1;
`ifdef NIBBLE_RX_SEQ_CHECK_EN
    mism = (w != m_exp);
    if (mism && m_ec != {CW{1'b1}}) m_ec = m_ec + 1'b1;
    if (m_first && !mism) begin
      m_lock = 1'b1;
      m_exp  = 1;
    end else begin
      m_exp = w + 1'b1;
    end
`else
    mism = 1'b0;
`endif
    m_first = 1'b0;
    e.data = w;
    e.err  = mism;
    e.lock = m_lock;
    e.wc   = m_wc;
    e.ec   = m_ec;
    sb_q.push_back(e);
  endtask

  task automatic start_frame();
    m_first = 1'b1;
    m_lock  = 1'b0;
    m_exp   = '1;
    repeat (1 + SDLY) cyc(1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) cyc(1'b0, w[i]);
    model_word(w);
    repeat (GAP) cyc(1'b0, 1'b0);
  endtask

  task automatic end_frame();
    repeat (4) cyc(1'b1, 1'b0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, sb_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data"}, rx_data, 0);
    check_eq({tag, "_valid"}, rx_valid, 0);
    check_eq({tag, "_err"}, rx_err, 0);
    check_eq({tag, "_locked"}, locked, 0);
    check_eq({tag, "_wc"}, word_count, 0);
    check_eq({tag, "_ec"}, err_count, 0);
  endtask

  // Monitor: pops the scoreboard on every rx_valid, and checks rx_err stays low otherwise.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rx_valid) begin
          if (sb_q.size() == 0) begin
            check_eq("unexpected_valid", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check_eq("rx_data", rx_data, e.data);
            check_eq("rx_err", rx_err, e.err);
            check_eq("locked", locked, e.lock);
            check_eq("word_count", word_count, e.wc);
            check_eq("err_count", err_count, e.ec);
          end
        end else begin
          check_eq("err_without_valid", rx_err, 0);
        end
      end
    end
  end

  initial begin
    rst  = 1'b1;
    SSEL = 1'b1;
    MOSI = 1'b0;
    m_wc = '0; m_ec = '0; m_lock = 1'b0; m_first = 1'b0; m_exp = '1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    end_frame();

    // Basic preamble plus two words.
    start_frame();
    send_word(4'hF); send_word(4'h1); send_word(4'h2);
    end_frame();
    drain("drain_basic");
    check_eq("basic_wc", word_count, 3);
    check_eq("basic_locked_hold", locked, m_lock);
    check_eq("basic_ec", err_count, 0);

    // 20 words including the F->0 wrap.
    start_frame();
    for (int i = 0; i < 20; i++) send_word((i == 0) ? 4'hF : 4'(i));
    end_frame();
    drain("drain_wrap");

    // Word 5 where 4 is expected, then 6.
    start_frame();
    send_word(4'hF); send_word(4'h1); send_word(4'h2); send_word(4'h3);
    send_word(4'h5); send_word(4'h6);
    end_frame();
    drain("drain_inject");

    // Abort after two bits of a word; locked holds, next frame relocks.
    start_frame();
    send_word(4'hF); send_word(4'h1);
    cyc(1'b0, 1'b0); cyc(1'b0, 1'b1);
    end_frame();
    repeat (4) cyc(1'b1, 1'b0);
    drain("drain_abort");
    check_eq("abort_locked_hold", locked, m_lock);
    check_eq("abort_wc", word_count, m_wc);
    start_frame();
    send_word(4'hF); send_word(4'h1);
    end_frame();
    drain("drain_relock");

    // Bad preamble 0111 then 8.
    start_frame();
    send_word(4'h7); send_word(4'h8);
    end_frame();
    drain("drain_badpre");
    check_eq("badpre_locked", locked, 0);

    // Reset in the middle of a word.
    start_frame();
    send_word(4'hF); send_word(4'h1);
    cyc(1'b0, 1'b0); cyc(1'b0, 1'b1); cyc(1'b0, 1'b0);
    @(negedge clk);
    rst  = 1'b1;
    SSEL = 1'b1;
    check_eq("rst_sb_empty", sb_q.size(), 0);
    sb_q.delete();
    m_wc = '0; m_ec = '0; m_lock = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    end_frame();
    start_frame();
    send_word(4'hF); send_word(4'h1);
    end_frame();
    drain("drain_fresh");
    check_eq("fresh_wc", word_count, 2);

    // 300 mismatching words to saturate both counters.
    start_frame();
    send_word(4'hF);
    for (int i = 0; i < 300; i++) send_word(m_exp + 4'd2);
    end_frame();
    drain("drain_sat");
    check_eq("sat_wc", word_count, 255);
`ifdef NIBBLE_RX_SEQ_CHECK_EN
    check_eq("sat_ec", err_count, 255);
`else
    check_eq("sat_ec", err_count, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
